// File: rtl/apb_reg_completer.sv
// APB completer for the register-module side of the bus. It holds a bank of
// 16-bit control registers behind a fixed, programmable-latency response, with
// a read-only ID in register 0 and a saturating debug count of error replies.
module apb_reg_completer #(
    parameter int          NUM_REGS    = 8,
    parameter logic [19:0] BASE_ADDR   = 20'h00000,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [15:0] ID_VALUE    = 16'hC0DE
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     psel_i,
    input  logic                     penable_i,
    input  logic                     pwrite_i,
    input  logic [1:0]               pstrb_i,
    input  logic [19:0]              paddr_i,
    input  logic [15:0]              pwdata_i,
    output logic [15:0]              prdata_o,
    output logic                     pready_o,
    output logic                     pslverr_o,
    output logic [16*NUM_REGS-1:0]   reg_out_o,
    output logic [NUM_REGS-1:0]      wr_pulse_o,
    output logic [7:0]               err_cnt_o
);

    localparam logic [3:0]  WAIT_LOAD  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [18:0] NUM_REGS_W = 19'(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic                  write_q;
    logic [1:0]            strb_q;
    logic [19:0]           addr_q;
    logic [15:0]           wdata_q;
    logic [15:0]           regs_q [1:NUM_REGS-1];
    logic [15:0]           prdata_q;
    logic                  pready_q;
    logic                  pslverr_q;
    logic [NUM_REGS-1:0]   wr_pulse_q;
    logic [7:0]            err_cnt_q;

    logic [15:0]           regView [NUM_REGS];
    logic [19:0]           decAddr;
    logic                  decWrite;
    logic [19:0]           decOffset;
    logic [18:0]           decIdx;
    logic                  decErr;
    logic [15:0]           decRdata;
    logic [NUM_REGS-1:0]   decPulse;
    logic                  goResp;

    // Register view with the constant ID in slot 0, also driving the flat bus.
    always_comb begin
        regView[0] = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) begin
            regView[i] = regs_q[i];
        end
    end

    // Flatten the register view onto reg_out, 16 bits per register.
    always_comb begin
        reg_out_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out_o[16*i +: 16] = regView[i];
        end
    end

    // Decode the live bus in IDLE (zero-wait responses) and the latched copy afterwards.
    always_comb begin
        decAddr   = (state_q == S_IDLE) ? paddr_i  : addr_q;
        decWrite  = (state_q == S_IDLE) ? pwrite_i : write_q;
        decOffset = decAddr - BASE_ADDR;
        decIdx    = decOffset[19:1];
        decErr    = (decAddr < BASE_ADDR) || (decIdx >= NUM_REGS_W) || decOffset[0]
                    || (decWrite && (decIdx == 19'd0));
        decRdata  = '0;
        decPulse  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (decIdx == 19'(i)) begin
                decRdata    = regView[i];
                decPulse[i] = 1'b1;
            end
        end
    end

    // A response is produced on the edge that moves the FSM into RESP.
    always_comb begin
        goResp = 1'b0;
        case (state_q)
            S_IDLE:  goResp = psel_i && !penable_i && (WAIT_CYCLES == 0);
            S_WAIT:  goResp = psel_i && penable_i && (cnt_q == 4'd0);
            default: goResp = 1'b0;
        endcase
    end

    // Transfer FSM with registered response outputs and the error counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            strb_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            prdata_q   <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            wr_pulse_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            prdata_q   <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            wr_pulse_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (psel_i && !penable_i) begin
                        write_q <= pwrite_i;
                        strb_q  <= pstrb_i;
                        addr_q  <= paddr_i;
                        wdata_q <= pwdata_i;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= WAIT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (!psel_i) begin
                        state_q <= S_IDLE;
                    end else if (penable_i) begin
                        if (cnt_q == 4'd0) begin
                            state_q <= S_RESP;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            if (goResp) begin
                pready_q   <= 1'b1;
                pslverr_q  <= decErr;
                prdata_q   <= (!decWrite && !decErr) ? decRdata : 16'h0000;
                wr_pulse_q <= (decWrite && !decErr) ? decPulse : '0;
                if (decErr && (err_cnt_q != 8'hFF)) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
        end
    end

    // Commit byte-strobed writes at the end of the RESP cycle flagged by wr_pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_pulse_q[i]) begin
                    if (strb_q[1]) begin
                        regs_q[i][15:8] <= wdata_q[15:8];
                    end
                    if (strb_q[0]) begin
                        regs_q[i][7:0] <= wdata_q[7:0];
                    end
                end
            end
        end
    end

    assign prdata_o   = prdata_q;
    assign pready_o   = pready_q;
    assign pslverr_o  = pslverr_q;
    assign wr_pulse_o = wr_pulse_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Bench for apb_reg_completer: three instances with 1, 3 and 0 wait states,
// table-driven vectors, hand sequences for abort/back-to-back/reset, and
// random transfers checked against an arithmetic register-bank model.
module tb_apb_reg_completer;

    localparam int NR = 8;

    typedef struct {
        logic        wr;
        logic [1:0]  strb;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [15:0] expR;
        logic        expErr;
        logic [7:0]  expPul;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic           psel    [3];
    logic           penable [3];
    logic           pwrite  [3];
    logic [1:0]     pstrb   [3];
    logic [19:0]    paddr   [3];
    logic [15:0]    pwdata  [3];
    logic [15:0]    prdata  [3];
    logic           pready  [3];
    logic           pslverr [3];
    logic [16*NR-1:0] regOut [3];
    logic [NR-1:0]  wrPulse [3];
    logic [7:0]     errCnt  [3];

    int waitCyc [3] = '{1, 3, 0};

    logic [15:0] mdlRegs [3][NR];
    int          mdlErr  [3];

    int checks = 0;
    int errors = 0;

    vec_t vecs [11];
    vec_t b2b  [3];

    always #5 clk = ~clk;

    apb_reg_completer #(.NUM_REGS(NR), .BASE_ADDR(20'h00000), .WAIT_CYCLES(1), .ID_VALUE(16'hC0DE)) u1 (
        .clk(clk), .reset_n(reset_n),
        .psel_i(psel[0]), .penable_i(penable[0]), .pwrite_i(pwrite[0]), .pstrb_i(pstrb[0]),
        .paddr_i(paddr[0]), .pwdata_i(pwdata[0]),
        .prdata_o(prdata[0]), .pready_o(pready[0]), .pslverr_o(pslverr[0]),
        .reg_out_o(regOut[0]), .wr_pulse_o(wrPulse[0]), .err_cnt_o(errCnt[0]));

    apb_reg_completer #(.NUM_REGS(NR), .BASE_ADDR(20'h00000), .WAIT_CYCLES(3), .ID_VALUE(16'hC0DE)) u3 (
        .clk(clk), .reset_n(reset_n),
        .psel_i(psel[1]), .penable_i(penable[1]), .pwrite_i(pwrite[1]), .pstrb_i(pstrb[1]),
        .paddr_i(paddr[1]), .pwdata_i(pwdata[1]),
        .prdata_o(prdata[1]), .pready_o(pready[1]), .pslverr_o(pslverr[1]),
        .reg_out_o(regOut[1]), .wr_pulse_o(wrPulse[1]), .err_cnt_o(errCnt[1]));

    apb_reg_completer #(.NUM_REGS(NR), .BASE_ADDR(20'h00000), .WAIT_CYCLES(0), .ID_VALUE(16'hC0DE)) u0 (
        .clk(clk), .reset_n(reset_n),
        .psel_i(psel[2]), .penable_i(penable[2]), .pwrite_i(pwrite[2]), .pstrb_i(pstrb[2]),
        .paddr_i(paddr[2]), .pwdata_i(pwdata[2]),
        .prdata_o(prdata[2]), .pready_o(pready[2]), .pslverr_o(pslverr[2]),
        .reg_out_o(regOut[2]), .wr_pulse_o(wrPulse[2]), .err_cnt_o(errCnt[2]));

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: applies one transfer's rules to the model bank.
    function automatic void modelXfer(input int d, input logic wr, input logic [1:0] strb,
                                      input logic [19:0] addr, input logic [15:0] wdata,
                                      output logic [15:0] expR, output logic expErr,
                                      output logic [7:0] expPul);
        int a;
        int idx;
        a      = int'(addr);
        idx    = a / 2;
        expErr = ((a % 2) != 0) || (idx >= NR) || (wr && (idx == 0));
        expR   = 16'h0000;
        expPul = 8'h00;
        if (expErr) begin
            if (mdlErr[d] < 255) mdlErr[d] = mdlErr[d] + 1;
        end else if (wr) begin
            if (strb[1]) mdlRegs[d][idx][15:8] = wdata[15:8];
            if (strb[0]) mdlRegs[d][idx][7:0]  = wdata[7:0];
            expPul = 8'(1 << idx);
        end else begin
            expR = mdlRegs[d][idx];
        end
    endfunction

    function automatic void modelReset();
        for (int d = 0; d < 3; d++) begin
            mdlErr[d] = 0;
            for (int i = 0; i < NR; i++) mdlRegs[d][i] = (i == 0) ? 16'hC0DE : 16'h0000;
        end
    endfunction

    // Drive one APB transfer starting just after a clock edge; ends just after the edge following pready.
    task automatic applyStimulus(input int d, input logic wr, input logic [1:0] strb,
                                 input logic [19:0] addr, input logic [15:0] wdata,
                                 output logic [15:0] rd, output logic er, output logic [7:0] pul,
                                 output int lat, output logic stray);
        rd = '0; er = 1'b0; pul = '0; lat = -1; stray = 1'b0;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        pstrb[d] = strb; paddr[d] = addr; pwdata[d] = wdata;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        paddr[d]  = ~addr;
        pwdata[d] = ~wdata;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (pready[d]) begin
                lat = k; rd = prdata[d]; er = pslverr[d]; pul = wrPulse[d];
                break;
            end
            if (pslverr[d] || (prdata[d] != 16'h0000) || (wrPulse[d] != '0)) stray = 1'b1;
        end
        @(posedge clk); #1;
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    task automatic checkRegs(input int d, input string tag);
        for (int i = 0; i < NR; i++) begin
            checkOutput($sformatf("%s reg%0d", tag, i), 32'(regOut[d][16*i +: 16]), 32'(mdlRegs[d][i]));
        end
    endtask

    // One transfer compared either against table constants or against the model.
    task automatic runXfer(input int d, input vec_t v, input logic useTable, input string tag);
        logic [15:0] mr, rd;
        logic        me, er, stray;
        logic [7:0]  mp, pul;
        int          lat;
        modelXfer(d, v.wr, v.strb, v.addr, v.wdata, mr, me, mp);
        if (useTable) begin
            mr = v.expR; me = v.expErr; mp = v.expPul;
        end
        applyStimulus(d, v.wr, v.strb, v.addr, v.wdata, rd, er, pul, lat, stray);
        checkOutput({tag, " latency"}, 32'(lat), 32'(1 + waitCyc[d]));
        checkOutput({tag, " prdata"}, 32'(rd), 32'(mr));
        checkOutput({tag, " pslverr"}, 32'(er), 32'(me));
        checkOutput({tag, " wr_pulse"}, 32'(pul), 32'(mp));
        checkOutput({tag, " idle outputs quiet"}, 32'(stray), 32'd0);
        checkRegs(d, tag);
        checkOutput({tag, " err_cnt"}, 32'(errCnt[d]), 32'(mdlErr[d]));
    endtask

    task automatic checkResetState(input int d, input string tag);
        checkOutput({tag, " pready"}, 32'(pready[d]), 32'd0);
        checkOutput({tag, " pslverr"}, 32'(pslverr[d]), 32'd0);
        checkOutput({tag, " prdata"}, 32'(prdata[d]), 32'd0);
        checkOutput({tag, " wr_pulse"}, 32'(wrPulse[d]), 32'd0);
        checkOutput({tag, " err_cnt"}, 32'(errCnt[d]), 32'd0);
        checkOutput({tag, " id"}, 32'(regOut[d][15:0]), 32'h0000C0DE);
        for (int i = 1; i < NR; i++) begin
            checkOutput($sformatf("%s reg%0d", tag, i), 32'(regOut[d][16*i +: 16]), 32'd0);
        end
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t rv;
        logic sawResp;

        for (int d = 0; d < 3; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            pstrb[d] = 2'b00; paddr[d] = '0; pwdata[d] = '0;
        end
        modelReset();

        vecs[0]  = '{1'b1, 2'b11, 20'h00002, 16'h1234, 16'h0000, 1'b0, 8'h02};
        vecs[1]  = '{1'b0, 2'b11, 20'h00002, 16'h0000, 16'h1234, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 2'b11, 20'h00004, 16'h1234, 16'h0000, 1'b0, 8'h04};
        vecs[3]  = '{1'b1, 2'b10, 20'h00004, 16'hABCD, 16'h0000, 1'b0, 8'h04};
        vecs[4]  = '{1'b0, 2'b11, 20'h00004, 16'h0000, 16'hAB34, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 2'b00, 20'h00004, 16'hFFFF, 16'h0000, 1'b0, 8'h04};
        vecs[6]  = '{1'b0, 2'b11, 20'h00004, 16'h0000, 16'hAB34, 1'b0, 8'h00};
        vecs[7]  = '{1'b1, 2'b11, 20'h00000, 16'h5555, 16'h0000, 1'b1, 8'h00};
        vecs[8]  = '{1'b0, 2'b11, 20'h00010, 16'h0000, 16'h0000, 1'b1, 8'h00};
        vecs[9]  = '{1'b0, 2'b11, 20'h00003, 16'h0000, 16'h0000, 1'b1, 8'h00};
        vecs[10] = '{1'b0, 2'b11, 20'h00000, 16'h0000, 16'hC0DE, 1'b0, 8'h00};

        b2b[0] = '{1'b1, 2'b11, 20'h00002, 16'h5A5A, 16'h0000, 1'b0, 8'h02};
        b2b[1] = '{1'b1, 2'b01, 20'h00004, 16'h0F0F, 16'h0000, 1'b0, 8'h04};
        b2b[2] = '{1'b0, 2'b11, 20'h00002, 16'h0000, 16'h5A5A, 1'b0, 8'h00};

        // Reset state on all instances.
        @(negedge clk);
        for (int d = 0; d < 3; d++) checkResetState(d, $sformatf("reset%0d", d));
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Table vectors on the one-wait-state instance.
        for (int i = 0; i < 11; i++) runXfer(0, vecs[i], 1'b1, $sformatf("vec%0d", i));
        checkOutput("table reg1", 32'(regOut[0][31:16]), 32'h00001234);
        checkOutput("table reg2", 32'(regOut[0][47:32]), 32'h0000AB34);
        checkOutput("table err_cnt", 32'(errCnt[0]), 32'd3);

        // Back-to-back on the zero-wait instance: consecutive calls leave no idle bubble.
        for (int i = 0; i < 3; i++) runXfer(2, b2b[i], 1'b1, $sformatf("b2b%0d", i));
        checkOutput("b2b reg2", 32'(regOut[2][47:32]), 32'h0000000F);

        // Abort on the three-wait instance.
        rv = '{1'b1, 2'b11, 20'h00006, 16'h1111, 16'h0000, 1'b0, 8'h08};
        runXfer(1, rv, 1'b1, "abort pre");
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        pstrb[1] = 2'b11; paddr[1] = 20'h00006; pwdata[1] = 16'h2222;
        @(posedge clk); #1;
        psel[1] = 1'b0;
        sawResp = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (pready[1] || (wrPulse[1] != '0)) sawResp = 1'b1;
        end
        checkOutput("abort no response", 32'(sawResp), 32'd0);
        checkOutput("abort reg3", 32'(regOut[1][63:48]), 32'h00001111);
        @(posedge clk); #1;
        rv = '{1'b0, 2'b11, 20'h00006, 16'h0000, 16'h1111, 1'b0, 8'h00};
        runXfer(1, rv, 1'b1, "abort post");

        // Random transfers against the model on every instance.
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 30; n++) begin
                rv.wr    = 1'($urandom_range(0, 1));
                rv.strb  = 2'($urandom_range(0, 3));
                rv.addr  = ($urandom_range(0, 9) == 0) ? 20'($urandom) : 20'($urandom_range(0, 19));
                rv.wdata = 16'($urandom);
                rv.expR = '0; rv.expErr = 1'b0; rv.expPul = '0;
                runXfer(d, rv, 1'b0, $sformatf("rand%0d_%0d", d, n));
            end
        end

        // Error counter saturation.
        rv = '{1'b0, 2'b11, 20'h00010, 16'h0000, 16'h0000, 1'b1, 8'h00};
        for (int n = 0; n < 260; n++) runXfer(0, rv, 1'b0, "sat");
        checkOutput("sat err_cnt", 32'(errCnt[0]), 32'h000000FF);

        // Reset asserted while both waiting instances are mid-WAIT.
        rv = '{1'b1, 2'b11, 20'h00002, 16'hBEEF, 16'h0000, 1'b0, 8'h02};
        runXfer(0, rv, 1'b1, "pre reset");
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1;
            pstrb[d] = 2'b11; paddr[d] = 20'h00002; pwdata[d] = 16'h7777;
        end
        @(posedge clk); #1;
        penable[0] = 1'b1; penable[1] = 1'b1;
        #2;
        reset_n = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) checkResetState(d, $sformatf("midreset%0d", d));
        psel[0] = 1'b0; penable[0] = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
        modelReset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        rv = '{1'b0, 2'b11, 20'h00002, 16'h0000, 16'h0000, 1'b0, 8'h00};
        runXfer(0, rv, 1'b1, "post reset read");
        runXfer(1, rv, 1'b1, "post reset read3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_reg_completer.md
Name: apb_reg_completer

Overview:
- APB completer (responder) for the register-module side of the APB bus. The SPI-side secure gate drives this bus as initiator.
- Accepts gated psel/penable/pwrite/pstrb/paddr/pwdata, and returns prdata/pready/pslverr with a programmable number of wait states.
- Holds a bank of 16-bit control registers with byte-strobed writes. Register 0 is a read-only ID.
- Flags decode errors and keeps a saturating error counter for debug.

Parameters:
- NUM_REGS, 8, number of 16-bit registers, including read-only reg 0; range 2..64.
- BASE_ADDR, 20'h00000, byte address of reg 0; must be even.
- WAIT_CYCLES, 1, wait states inserted before pready; range 0..15.
- ID_VALUE, 16'hC0DE, constant returned by reg 0.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- psel  in  1  completer select
- penable  in  1  APB access phase
- pwrite  in  1  1 = write, 0 = read
- pstrb  in  2  byte strobes: [1] = bits 15:8, [0] = bits 7:0
- paddr  in  20  byte address
- pwdata  in  16  write data
- prdata  out  16  read data, valid only while pready=1
- pready  out  1  transfer complete
- pslverr  out  1  error response, valid only while pready=1
- reg_out  out  16*NUM_REGS  flattened register contents; reg i occupies bits 16i+15:16i
- wr_pulse  out  NUM_REGS  one-cycle strobe per register on committed write
- err_cnt  out  8  saturating count of pslverr responses

Behaviour:
- Reset: reset_n is asynchronous and active-low; the clock is clk.
  - During reset, prdata=0, pready=0, pslverr=0, wr_pulse=0, err_cnt=0, and registers 1..NUM_REGS-1 = 0.
  - reg_out slice 0 always equals ID_VALUE.
  - Reset mid-transfer aborts it: no write is committed and the FSM returns to IDLE.
- FSM states:
  - IDLE: while psel=1 and penable=0 (setup cycle S), latch pwrite/pstrb/paddr/pwdata. Go to RESP if WAIT_CYCLES=0, else go to WAIT with the counter loaded to WAIT_CYCLES-1.
  - WAIT: decrement the counter each cycle. Go to RESP when the counter is 0 and psel=1.
  - RESP: one cycle only, then IDLE.
- Timing: pready, prdata and pslverr are registered and high exactly in cycle S+1+WAIT_CYCLES, for one cycle.
- Abort: psel=0 in any cycle after S and before RESP sends the FSM to IDLE, with no pready and no write.
- penable=0 while psel=1 in WAIT is a protocol violation; the FSM holds its count.
- Decode, evaluated on latched values:
  - idx = (paddr-BASE_ADDR)>>1.
  - Error if paddr<BASE_ADDR, idx>=NUM_REGS, paddr[0]=1, or the transfer is a write to idx 0.
- Read: prdata = reg[idx], or 0 on error.
- Write, no error: in the RESP cycle, reg[idx][15:8] is updated if pstrb[1] and reg[idx][7:0] if pstrb[0], and wr_pulse[idx]=1 in the same cycle.
  - The write takes effect in reg_out the cycle after RESP.
  - pstrb=2'b00 is legal: nothing is written but wr_pulse still fires.
- Error response: pslverr=1 with pready, prdata=0, no register change, no wr_pulse. err_cnt increments, saturating at 8'hFF.
- pslverr, prdata and wr_pulse are 0 whenever pready=0.
- Back-to-back transfers: a setup cycle (psel=1, penable=0) arriving in the cycle right after RESP is accepted from IDLE with no bubble.
- Latched values are used for the whole transfer; changes on paddr/pwdata after S are ignored.

Test Plan:
1. WAIT_CYCLES=1: write 16'h1234 to 20'h00002 with pstrb=11, then read it back. Required: pready high in cycle S+2 each time, wr_pulse[1] pulses once, reg_out[31:16]=16'h1234, read returns 16'h1234 with pslverr=0.
2. Byte strobes: starting from reg 2=16'h1234, write 16'hABCD to 20'h00004 with pstrb=2'b10. Required: reg 2 becomes 16'hAB34; then pstrb=2'b00 leaves reg 2 unchanged while wr_pulse[2] still pulses.
3. Errors: write to 20'h00000 (reg 0), read 20'h00010 (idx 8 with NUM_REGS=8), read 20'h00003 (misaligned). Required: each returns pslverr=1 with prdata=0, reg 0 still reads 16'hC0DE, err_cnt=3.
4. Abort: drop psel in the cycle after setup with WAIT_CYCLES=3. Required: no pready, register unchanged, next transfer completes normally.
5. Back-to-back with WAIT_CYCLES=0: three consecutive transfers, each setup immediately following the previous RESP. Required: pready high every second cycle, all data correct.
6. Saturation and reset: 260 error transfers. Required: err_cnt=8'hFF. Then assert reset_n low mid-WAIT: all outputs and registers cleared, ID intact.
